// File: rtl/pll_reset_pkg.sv
// Shared definitions for the PLL lock consumer: FSM state encodings, default timing
// constants and a small helper used to size the shared cycle counter.
package pll_reset_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK  = 3'd0,
        ST_STABILIZE  = 3'd1,
        ST_REL_PERIPH = 3'd2,
        ST_RUN        = 3'd3,
        ST_SOFT       = 3'd4,
        ST_LOST       = 3'd5
    } state_e;

    localparam int DEF_SYNC_STAGES        = 2;
    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_STAGE_GAP_CYCLES   = 16;
    localparam int DEF_SOFT_RESET_CYCLES  = 64;
    localparam int DEF_LOSS_CNT_WIDTH     = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchronizer for a level that is asynchronous to clk.
// All stages clear to 0 on reset so a stale "locked" level cannot leak through.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns the raw PLL lock flag into ordered peripheral/core resets, re-enters reset on
// lock loss (counting events) and services core-only soft reset requests from the CPU.
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int STAGE_GAP_CYCLES   = DEF_STAGE_GAP_CYCLES,
    parameter int SOFT_RESET_CYCLES  = DEF_SOFT_RESET_CYCLES,
    parameter int LOSS_CNT_WIDTH     = DEF_LOSS_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      isLocked,
    input  logic                      softResetReq,
    output logic                      periphReset,
    output logic                      coreReset,
    output logic                      isReady,
    output logic [LOSS_CNT_WIDTH-1:0] lockLossCount
);

    localparam int CNT_W = $clog2(max3(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES, SOFT_RESET_CYCLES) + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LOCK_LAST = cnt_t'(LOCK_STABLE_CYCLES - 1);
    localparam cnt_t GAP_LAST  = cnt_t'(STAGE_GAP_CYCLES - 1);
    localparam cnt_t SOFT_LAST = cnt_t'(SOFT_RESET_CYCLES - 1);

    state_e                    state_q;
    cnt_t                      cnt_q;
    logic                      periph_q;
    logic                      core_q;
    logic                      ready_q;
    logic [LOSS_CNT_WIDTH-1:0] loss_q;
    logic [LOSS_CNT_WIDTH-1:0] loss_d;
    logic                      lock_sync;
    logic                      lock_lost;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (reset),
        .d_i (isLocked),
        .q_o (lock_sync)
    );

    assign loss_d    = (&loss_q) ? loss_q : loss_q + LOSS_CNT_WIDTH'(1);
    // Once the peripherals have been released, a drop overrides every other transition.
    assign lock_lost = !lock_sync &&
                       (state_q == ST_REL_PERIPH || state_q == ST_RUN || state_q == ST_SOFT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_WAIT_LOCK;
            cnt_q    <= '0;
            periph_q <= 1'b1;
            core_q   <= 1'b1;
            ready_q  <= 1'b0;
            loss_q   <= '0;
        end else if (lock_lost) begin
            state_q  <= ST_LOST;
            cnt_q    <= '0;
            periph_q <= 1'b1;
            core_q   <= 1'b1;
            ready_q  <= 1'b0;
            loss_q   <= loss_d;
        end else begin
            case (state_q)
                ST_WAIT_LOCK, ST_LOST: begin
                    if (lock_sync) begin
                        state_q <= ST_STABILIZE;
                        cnt_q   <= '0;
                    end
                end
                ST_STABILIZE: begin
                    if (!lock_sync) begin
                        state_q <= ST_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_q  <= ST_REL_PERIPH;
                        cnt_q    <= '0;
                        periph_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + cnt_t'(1);
                    end
                end
                ST_REL_PERIPH: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                        core_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + cnt_t'(1);
                    end
                end
                ST_RUN: begin
                    if (softResetReq) begin
                        state_q <= ST_SOFT;
                        cnt_q   <= '0;
                        core_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                ST_SOFT: begin
                    if (cnt_q == SOFT_LAST) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                        core_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + cnt_t'(1);
                    end
                end
                default: begin
                    state_q  <= ST_WAIT_LOCK;
                    cnt_q    <= '0;
                    periph_q <= 1'b1;
                    core_q   <= 1'b1;
                    ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign periphReset   = periph_q;
    assign coreReset     = core_q;
    assign isReady       = ready_q;
    assign lockLossCount = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters (2/8/4/6, 2-bit loss count).
module tb_pll_reset_sequencer;
    import pll_reset_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       isLocked;
    logic       softResetReq;
    logic       periphReset;
    logic       coreReset;
    logic       isReady;
    logic [1:0] lockLossCount;

    int checks = 0;
    int errors = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .STAGE_GAP_CYCLES   (4),
        .SOFT_RESET_CYCLES  (6),
        .LOSS_CNT_WIDTH     (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .isLocked      (isLocked),
        .softResetReq  (softResetReq),
        .periphReset   (periphReset),
        .coreReset     (coreReset),
        .isReady       (isReady),
        .lockLossCount (lockLossCount)
    );

    always #5 clk = ~clk;

    // Each step advances exactly one rising edge; outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        isLocked     = 1'b1;
        softResetReq = 1'b0;
        step(3);
        checks++;
        if ({periphReset, coreReset, isReady} !== 3'b110) begin
            errors++;
            $display("FAIL reset_outputs got %b want 110", {periphReset, coreReset, isReady});
        end
        checks++;
        if (lockLossCount !== 2'd0) begin
            errors++;
            $display("FAIL reset_loss got %0d want 0", lockLossCount);
        end
        $display("test_reset done");
    endtask

    task automatic test_power_up();
        logic [2:0] exp;
        reset = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            step(1);
            exp = {e < 11, e < 15, e >= 15};
            checks++;
            if ({periphReset, coreReset, isReady} !== exp) begin
                errors++;
                $display("FAIL power_up edge %0d got %b want %b", e, {periphReset, coreReset, isReady}, exp);
            end
        end
        $display("test_power_up done");
    endtask

    task automatic test_unstable();
        logic [2:0] exp;
        reset    = 1'b1;
        isLocked = 1'b0;
        step(2);
        reset = 1'b0;
        step(2);
        isLocked = 1'b1;
        step(5);
        isLocked = 1'b0;
        step(1);
        isLocked = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            step(1);
            exp = {e < 11, e < 15, e >= 15};
            checks++;
            if ({periphReset, coreReset, isReady} !== exp) begin
                errors++;
                $display("FAIL unstable edge %0d got %b want %b", e, {periphReset, coreReset, isReady}, exp);
            end
        end
        checks++;
        if (lockLossCount !== 2'd0) begin
            errors++;
            $display("FAIL unstable_loss got %0d want 0", lockLossCount);
        end
        $display("test_unstable done");
    endtask

    task automatic test_lock_loss();
        logic [2:0] exp;
        isLocked = 1'b0;
        step(2);
        checks++;
        if ({periphReset, coreReset, isReady} !== 3'b001) begin
            errors++;
            $display("FAIL loss_edge2 got %b want 001", {periphReset, coreReset, isReady});
        end
        step(1);
        checks++;
        if ({periphReset, coreReset, isReady} !== 3'b110) begin
            errors++;
            $display("FAIL loss_edge3 got %b want 110", {periphReset, coreReset, isReady});
        end
        checks++;
        if (lockLossCount !== 2'd1) begin
            errors++;
            $display("FAIL loss_count got %0d want 1", lockLossCount);
        end
        // Soft requests during requalification must be ignored.
        isLocked = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            softResetReq = (e < 15);
            step(1);
            exp = {e < 11, e < 15, e >= 15};
            checks++;
            if ({periphReset, coreReset, isReady} !== exp) begin
                errors++;
                $display("FAIL relock edge %0d got %b want %b", e, {periphReset, coreReset, isReady}, exp);
            end
        end
        softResetReq = 1'b0;
        checks++;
        if (lockLossCount !== 2'd1) begin
            errors++;
            $display("FAIL relock_loss got %0d want 1", lockLossCount);
        end
        $display("test_lock_loss done");
    endtask

    task automatic test_soft_reset();
        logic [2:0] exp;
        softResetReq = 1'b1;
        step(1);
        softResetReq = 1'b0;
        checks++;
        if ({periphReset, coreReset, isReady} !== 3'b010) begin
            errors++;
            $display("FAIL soft_entry got %b want 010", {periphReset, coreReset, isReady});
        end
        for (int k = 1; k <= 7; k++) begin
            step(1);
            exp = {1'b0, k < 6, k >= 6};
            checks++;
            if ({periphReset, coreReset, isReady} !== exp) begin
                errors++;
                $display("FAIL soft edge s+%0d got %b want %b", k, {periphReset, coreReset, isReady}, exp);
            end
        end
        $display("test_soft_reset done");
    endtask

    task automatic test_priority();
        isLocked = 1'b0;
        step(2);
        softResetReq = 1'b1;
        step(1);
        softResetReq = 1'b0;
        checks++;
        if ({periphReset, coreReset, isReady} !== 3'b110) begin
            errors++;
            $display("FAIL priority_outputs got %b want 110", {periphReset, coreReset, isReady});
        end
        checks++;
        if (lockLossCount !== 2'd2) begin
            errors++;
            $display("FAIL priority_loss got %0d want 2", lockLossCount);
        end
        step(1);
        checks++;
        if ({periphReset, coreReset, isReady} !== 3'b110) begin
            errors++;
            $display("FAIL priority_hold got %b want 110", {periphReset, coreReset, isReady});
        end
        isLocked = 1'b1;
        step(15);
        checks++;
        if ({periphReset, coreReset, isReady} !== 3'b001) begin
            errors++;
            $display("FAIL priority_rerun got %b want 001", {periphReset, coreReset, isReady});
        end
        $display("test_priority done");
    endtask

    task automatic test_saturation();
        isLocked = 1'b0;
        step(3);
        checks++;
        if (lockLossCount !== 2'd3) begin
            errors++;
            $display("FAIL sat_third got %0d want 3", lockLossCount);
        end
        isLocked = 1'b1;
        step(15);
        isLocked = 1'b0;
        step(3);
        checks++;
        if (lockLossCount !== 2'd3) begin
            errors++;
            $display("FAIL sat_fourth got %0d want 3", lockLossCount);
        end
        checks++;
        if ({periphReset, coreReset, isReady} !== 3'b110) begin
            errors++;
            $display("FAIL sat_outputs got %b want 110", {periphReset, coreReset, isReady});
        end
        isLocked = 1'b1;
        step(12);
        checks++;
        if ({periphReset, coreReset, isReady} !== 3'b010) begin
            errors++;
            $display("FAIL mid_rel_periph got %b want 010", {periphReset, coreReset, isReady});
        end
        // Assert reset between clock edges: outputs must respond without a clock.
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({periphReset, coreReset, isReady} !== 3'b110) begin
            errors++;
            $display("FAIL async_reset_outputs got %b want 110", {periphReset, coreReset, isReady});
        end
        checks++;
        if (lockLossCount !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_loss got %0d want 0", lockLossCount);
        end
        step(1);
        reset = 1'b0;
        $display("test_saturation done");
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_unstable();
        test_lock_loss();
        test_soft_reset();
        test_priority();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
